// File: rtl/div_unit_ctrl.sv
`timescale 1ns/1ps
// div_unit_ctrl: valid/ready front/back end around a multicycle 32-bit unsigned divide core.
// Handles RISC-V DIV/DIVU/REM/REMU sign fix-up and the divide-by-zero / overflow results.
module div_unit_ctrl #(
    parameter int unsigned CORE_LATENCY = 4,
    parameter int unsigned TAG_W        = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [31:0]      in_a,
    input  logic [31:0]      in_b,
    input  logic [TAG_W-1:0] in_tag,
    output logic [31:0]      core_a,
    output logic [31:0]      core_b,
    input  logic [31:0]      core_quotient,
    input  logic [31:0]      core_remainder,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [3:0]  LAT     = 4'(CORE_LATENCY);
    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    state_t      state, state_next;
    logic [3:0]  counter;
    logic        is_rem, neg_a, neg_b;
    logic        accept, finish;
    logic        in_signed, in_neg_a, in_neg_b;
    logic        div_zero, overflow, special;
    logic [31:0] mag_a, mag_b, special_result, quot_fix, rem_fix;

    // Request decode: magnitudes for the core and the two results that bypass it.
    always_comb begin
        in_signed = ~in_op[0];
        in_neg_a  = in_signed & in_a[31];
        in_neg_b  = in_signed & in_b[31];
        mag_a     = in_neg_a ? (~in_a + 32'd1) : in_a;
        mag_b     = in_neg_b ? (~in_b + 32'd1) : in_b;
        div_zero  = (in_b == 32'd0);
        overflow  = in_signed && (in_a == INT_MIN) && (in_b == 32'hFFFF_FFFF);
        special   = div_zero | overflow;
        if (div_zero)
            special_result = in_op[1] ? in_a : 32'hFFFF_FFFF;
        else
            special_result = in_op[1] ? 32'd0 : INT_MIN;
    end

    assign quot_fix = (neg_a ^ neg_b) ? (~core_quotient + 32'd1) : core_quotient;
    assign rem_fix  = neg_a ? (~core_remainder + 32'd1) : core_remainder;

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        accept     = 1'b0;
        finish     = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                accept   = in_valid & ~flush;
                if (accept)
                    state_next = special ? DONE : BUSY;
            end
            BUSY: begin
                finish = (counter == 4'd1) & ~flush;
                if (finish)
                    state_next = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (flush)
            state_next = IDLE;
    end

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter    <= '0;
            is_rem     <= 1'b0;
            neg_a      <= 1'b0;
            neg_b      <= 1'b0;
            core_a     <= '0;
            core_b     <= '0;
            out_result <= '0;
            out_tag    <= '0;
        end else if (flush) begin
            counter <= '0;
        end else if (accept) begin
            is_rem  <= in_op[1];
            neg_a   <= in_neg_a;
            neg_b   <= in_neg_b;
            core_a  <= mag_a;
            core_b  <= mag_b;
            out_tag <= in_tag;
            counter <= special ? 4'd0 : LAT;
            if (special)
                out_result <= special_result;
        end else if (state == BUSY) begin
            // The core inputs have been stable for CORE_LATENCY cycles when counter is 1.
            counter <= counter - 4'd1;
            if (finish)
                out_result <= is_rem ? rem_fix : quot_fix;
        end
    end

endmodule

// File: tb/tb_div_unit_ctrl.sv
`timescale 1ns/1ps
// tb_div_unit_ctrl: randomized and directed checks of div_unit_ctrl against an arithmetic model,
// with a divide core that returns corrupted values until its inputs have settled.
module tb_div_unit_ctrl;

    localparam int unsigned CORE_LATENCY = 4;
    localparam int unsigned TAG_W        = 5;
    localparam int          PERIOD       = 10;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_a, in_b;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      core_a, core_b;
    logic [31:0]      core_quotient, core_remainder;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;

    int total = 0;
    int bad   = 0;

    div_unit_ctrl #(.CORE_LATENCY(CORE_LATENCY), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .core_a(core_a), .core_b(core_b),
        .core_quotient(core_quotient), .core_remainder(core_remainder),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    always #(PERIOD/2) clk = ~clk;

    // Divide core: outputs are garbage unless the inputs will have been stable
    // for CORE_LATENCY full cycles at the coming rising edge.
    time chg_t = 0;
    always @(core_a or core_b) chg_t = $time;
    always @(negedge clk) begin
        logic [31:0] q, r;
        q = (core_b == 32'd0) ? 32'hFFFF_FFFF : core_a / core_b;
        r = (core_b == 32'd0) ? core_a : core_a % core_b;
        if ($time + PERIOD/2 - chg_t >= time'(CORE_LATENCY * PERIOD)) begin
            core_quotient  = q;
            core_remainder = r;
        end else begin
            core_quotient  = q ^ 32'h5A5A_A5A5;
            core_remainder = r ^ 32'hC3C3_3C3C;
        end
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Reference model: RISC-V M-extension semantics in plain arithmetic.
    function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
        if (!op[0]) begin
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
            return op[1] ? 32'(sa % sb) : 32'(sa / sb);
        end
        return op[1] ? a % b : a / b;
    endfunction

    function automatic bit is_special(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    function automatic logic [31:0] magnitude(input logic [31:0] v, input bit is_signed);
        return (is_signed && v[31]) ? 32'd0 - v : v;
    endfunction

    // Issue one request at a falling edge, then check core drive, latency, result, tag and handshake.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [TAG_W-1:0] tag, input int hold);
        logic [31:0]      exp_res, held_res;
        logic [TAG_W-1:0] held_tag;
        int               exp_lat, lat;
        exp_res = ref_result(op, a, b);
        exp_lat = is_special(op, a, b) ? 1 : CORE_LATENCY + 1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_tag   = tag;
        @(negedge clk);
        in_valid = 1'b0;
        in_op    = 2'($urandom);
        in_a     = $urandom;
        in_b     = $urandom;
        in_tag   = TAG_W'($urandom);
        check("core_a", core_a, magnitude(a, !op[0]));
        check("core_b", core_b, magnitude(b, !op[0]));
        check("in_ready_after_accept", 32'(in_ready), 32'd0);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", out_result, exp_res);
        check("out_tag", 32'(out_tag), 32'(tag));
        held_res = out_result;
        held_tag = out_tag;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_result", out_result, exp_res);
            check("hold_tag", 32'(out_tag), 32'(held_tag));
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("consumed_valid", 32'(out_valid), 32'd0);
        check("consumed_in_ready", 32'(in_ready), 32'd1);
        if (held_res !== exp_res) check("held_result", held_res, exp_res);
    endtask

    // Watch for any out_valid over a number of cycles after an aborted operation.
    task automatic expect_no_valid(input string tag, input int cycles);
        int seen;
        seen = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        check(tag, 32'(seen), 32'd0);
    endtask

    function automatic logic [31:0] pick_operand();
        unique case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'hFFFF_FFFF;
            2: return 32'($urandom_range(0, 20));
            3: return 32'd0 - 32'($urandom_range(1, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_op     = 2'b00;
        in_a      = '0;
        in_b      = '0;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_result", out_result, 32'd0);
        check("reset_out_tag", 32'(out_tag), 32'd0);
        check("reset_core_a", core_a, 32'd0);
        check("reset_core_b", core_b, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed vectors: signed fix-up, unsigned ops, divide by zero, overflow.
        run_op(2'b00, 32'hFFFF_FFF9, 32'd2,         5'd1, 0);
        run_op(2'b10, 32'hFFFF_FFF9, 32'd2,         5'd2, 0);
        run_op(2'b01, 32'hFFFF_FFFF, 32'd2,         5'd3, 0);
        run_op(2'b11, 32'd7,         32'hFFFF_FFF9, 5'd4, 0);
        run_op(2'b10, 32'd7,         32'hFFFF_FFFE, 5'd5, 0);
        run_op(2'b00, 32'd7,         32'hFFFF_FFFE, 5'd6, 0);
        run_op(2'b00, 32'd5,         32'd0,         5'd7, 0);
        run_op(2'b10, 32'd5,         32'd0,         5'd8, 0);
        run_op(2'b01, 32'd5,         32'd0,         5'd9, 0);
        run_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 0);
        run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0);
        run_op(2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0);

        // Backpressure: result held for ten cycles with out_ready low.
        run_op(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd13, 10);

        // Randomized operations with corner-heavy operands.
        for (int n = 0; n < 40; n++)
            run_op(2'($urandom), pick_operand(), pick_operand(), TAG_W'($urandom), $urandom_range(0, 2));

        // flush in BUSY with counter at 2.
        in_valid = 1'b1; in_op = 2'b00; in_a = 32'd50; in_b = 32'd3; in_tag = 5'd21;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (CORE_LATENCY - 2) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy_in_ready", 32'(in_ready), 32'd1);
        expect_no_valid("flush_busy_no_valid", CORE_LATENCY + 4);

        // flush coinciding with a request in IDLE: not accepted.
        in_valid = 1'b1; in_op = 2'b01; in_a = 32'd9; in_b = 32'd2; in_tag = 5'd22;
        flush = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        flush = 1'b0;
        check("flush_idle_in_ready", 32'(in_ready), 32'd1);
        expect_no_valid("flush_idle_no_valid", CORE_LATENCY + 4);

        // flush in DONE discards the result.
        in_valid = 1'b1; in_op = 2'b00; in_a = 32'd9; in_b = 32'd0; in_tag = 5'd23;
        @(negedge clk);
        in_valid = 1'b0;
        check("done_before_flush", 32'(out_valid), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_done_valid", 32'(out_valid), 32'd0);
        check("flush_done_in_ready", 32'(in_ready), 32'd1);

        // Asynchronous reset mid-BUSY.
        in_valid = 1'b1; in_op = 2'b00; in_a = 32'd77; in_b = 32'd5; in_tag = 5'd24;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_in_ready", 32'(in_ready), 32'd1);
        check("async_reset_core_a", core_a, 32'd0);
        check("async_reset_out_tag", 32'(out_tag), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        expect_no_valid("reset_no_valid", CORE_LATENCY + 4);

        run_op(2'b01, 32'd100, 32'd7, 5'd3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/div_unit_ctrl.md
Name: div_unit_ctrl

Overview:
- Sequential front/back end for the 32-bit combinational unsigned divide core: accepts RISC-V M-extension divide ops (DIV/DIVU/REM/REMU) through a valid/ready handshake.
- Converts signed operands to magnitudes and drives the core from registers, waiting a programmable number of cycles for the core to settle.
- Applies sign fix-up and the RISC-V special cases, and returns a registered result with a tag to the writeback stage.

Parameters:
- CORE_LATENCY, 4, cycles the core outputs need to settle after its inputs change (multicycle path); legal range 1..15.
- TAG_W, 5, width of the destination-register tag passed through unchanged.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous abort of any in-flight or pending operation.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request.
- in_op  in  2  operation: 00 DIV, 01 DIVU, 10 REM, 11 REMU (funct3[1:0]).
- in_a  in  32  dividend (rs1).
- in_b  in  32  divisor (rs2).
- in_tag  in  TAG_W  destination tag.
- core_a  out  32  dividend magnitude to the divide core.
- core_b  out  32  divisor magnitude to the divide core.
- core_quotient  in  32  unsigned quotient from the core.
- core_remainder  in  32  unsigned remainder from the core.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_result  out  32  quotient (DIV/DIVU) or remainder (REM/REMU).
- out_tag  out  TAG_W  tag of the result.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_result=0, out_tag=0, core_a=0, core_b=0, counter=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch op, tag, signed flag (op[0]==0), neg_a and neg_b (signed & sign bit), and core_a/core_b = |in_a| / |in_b| (two's-complement negate when negative; |0x80000000| = 0x80000000 unsigned).
  - Divide by zero (in_b==0) or signed overflow (signed, in_a=0x80000000, in_b=0xFFFFFFFF): go directly to DONE with the special result. Otherwise load counter=CORE_LATENCY and go to BUSY.
- BUSY:
  - in_ready=0; the counter decrements each cycle.
  - On the cycle the counter reaches 1: register the fixed-up result and go to DONE.
  - Quotient sign = neg_a XOR neg_b; remainder sign = neg_a. Negate the core output when its sign is set; unsigned ops use the core outputs unchanged.
- Special results:
  - Divide by zero: quotient 0xFFFFFFFF (both DIV and DIVU), remainder = in_a unchanged.
  - Overflow: quotient 0x80000000, remainder 0.
- DONE:
  - out_valid=1; out_result and out_tag are held stable until out_ready.
  - On out_valid&out_ready: go to IDLE. in_ready=0 in DONE (no overlap).
- Latency from the accept edge:
  - Normal ops: out_valid rises CORE_LATENCY+1 cycles after accept.
  - Special cases: out_valid rises 1 cycle after accept.
- core_a/core_b: change only on accept and stay stable through BUSY; the core always sees stable inputs for at least CORE_LATENCY cycles.
- flush:
  - Has priority over everything: next state IDLE, out_valid=0, counter=0; core_a/core_b keep their values. Any result in DONE is discarded.
  - flush coinciding with in_valid in IDLE: the request is not accepted.
- Reset mid-operation: outputs return to reset values immediately (asynchronous); no result is produced.

Test Plan:
- DIV a=0xFFFFFFF9 (-7), b=2, CORE_LATENCY=4 -> core_a=7, core_b=2; out_valid 5 cycles after accept; out_result=0xFFFFFFFD (-3); REM on same operands -> 0xFFFFFFFF (-1).
- DIVU a=0xFFFFFFFF, b=2 -> 0x7FFFFFFF; REMU a=7, b=0xFFFFFFF9 -> 7; REM a=7, b=0xFFFFFFFE (-2) -> 1, DIV -> 0xFFFFFFFD.
- Divide by zero: DIV a=5, b=0 -> 0xFFFFFFFF; REM a=5, b=0 -> 5; each out_valid 1 cycle after accept.
- Overflow: DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000; REM -> 0; DIVU on same operands -> 0 after normal latency.
- Backpressure: out_ready held low 10 cycles -> out_valid, out_result and out_tag stable and in_ready=0 throughout; the result is consumed on the first cycle out_ready=1, and in_ready=1 the next cycle.
- flush asserted in BUSY (counter=2), and rst_n pulsed low mid-BUSY -> IDLE, out_valid never asserts for that tag; a subsequent DIVU 100/7 with tag 3 returns 14 with out_tag=3.
